// File: rtl/mux6_rr_arbiter.sv
// mux6_rr_arbiter: round-robin owner of a shared 6-to-1 WIDTH-bit selector.
// A winning source's word is captured into an output register. The word is
// offered with valid/ready, and a one-cycle gnt pulse reports its acceptance.
// Optional build macro MUX6_ARB_PRIO0_EN gives source 0 strict priority.
// Source 0 handshakes then leave the round-robin pointer untouched.
module mux6_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int RESET_PTR = 5
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [5:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    input  logic [WIDTH-1:0] data4,
    input  logic [WIDTH-1:0] data5,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       sel,
    output logic [5:0]       gnt,
    output logic             busy
);

    localparam logic [2:0] SEL_IDLE = 3'b111;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       ptr_reg, ptr_next;
    logic             valid_reg, valid_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [2:0]       sel_reg, sel_next;
    logic [5:0]       gnt_reg, gnt_next;
    logic             busy_reg, busy_next;

    logic [WIDTH-1:0] data_arr [6];
    logic [5:0]       above_ptr;
    logic [2:0]       hi_idx, lo_idx, win_idx;
    logic             hi_any;

    assign data_arr[0] = data0;
    assign data_arr[1] = data1;
    assign data_arr[2] = data2;
    assign data_arr[3] = data3;
    assign data_arr[4] = data4;
    assign data_arr[5] = data5;

    // Requests strictly after the last-granted index get the first look.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_above
            assign above_ptr[gi] = req[gi] && (3'(gi) > ptr_reg);
        end
    endgenerate

    // Lowest requester above ptr wins; otherwise the scan wraps to the lowest overall.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = 3'd0;
        lo_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (above_ptr[i]) begin
                hi_any = 1'b1;
                hi_idx = 3'(i);
            end
            if (req[i]) begin
                lo_idx = 3'(i);
            end
        end
        win_idx = hi_any ? hi_idx : lo_idx;
`ifdef MUX6_ARB_PRIO0_EN
        if (req[0]) begin
            win_idx = 3'd0;
        end
`endif
    end

    // Next-state and registered-output values for the IDLE/HOLD sequencer.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        valid_next = valid_reg;
        data_next  = data_reg;
        sel_next   = sel_reg;
        gnt_next   = 6'b0;
        busy_next  = busy_reg;
        case (state_reg)
            IDLE: begin
                valid_next = 1'b0;
                data_next  = '0;
                sel_next   = SEL_IDLE;
                busy_next  = 1'b0;
                if (req != 6'b0) begin
                    state_next = HOLD;
                    valid_next = 1'b1;
                    data_next  = data_arr[win_idx];
                    sel_next   = win_idx;
                    busy_next  = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                    gnt_next   = 6'b000001 << sel_reg;
`ifdef MUX6_ARB_PRIO0_EN
                    if (sel_reg != 3'd0) begin
                        ptr_next = sel_reg;
                    end
`else
                    ptr_next = sel_reg;
`endif
                    valid_next = 1'b0;
                    data_next  = '0;
                    sel_next   = SEL_IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any held word without a grant.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_reg <= IDLE;
            ptr_reg   <= 3'(RESET_PTR);
            valid_reg <= 1'b0;
            data_reg  <= '0;
            sel_reg   <= SEL_IDLE;
            gnt_reg   <= 6'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            valid_reg <= valid_next;
            data_reg  <= data_next;
            sel_reg   <= sel_next;
            gnt_reg   <= gnt_next;
            busy_reg  <= busy_next;
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign sel       = sel_reg;
    assign gnt       = gnt_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// tb_mux6_rr_arbiter: directed and randomized checks of mux6_rr_arbiter.
// The checks compare against a transaction-level reference model.
// Build with MUX6_ARB_PRIO0_EN defined to check the strict source-0 priority variant.
module tb_mux6_rr_arbiter;

    localparam int WIDTH     = 4;
    localparam int RESET_PTR = 5;

    logic             clk = 1'b0;
    logic             areset;
    logic [5:0]       req;
    logic [WIDTH-1:0] dat [6];
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       sel;
    logic [5:0]       gnt;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner index (-1 when idle), last-granted pointer, captured word.
    int m_owner;
    int m_ptr;
    int m_word;
    int m_gnt;

    mux6_rr_arbiter #(.WIDTH(WIDTH), .RESET_PTR(RESET_PTR)) dut (
        .clk(clk), .areset(areset), .req(req),
        .data0(dat[0]), .data1(dat[1]), .data2(dat[2]),
        .data3(dat[3]), .data4(dat[4]), .data5(dat[5]),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .sel(sel), .gnt(gnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Winner by the rules: source 0 first if prioritised, else first requester after ptr, mod 6.
    function automatic int pick(input logic [5:0] r, input int p);
`ifdef MUX6_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= 6; k++) begin
            if (r[(p + k) % 6]) return (p + k) % 6;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = RESET_PTR;
        m_word  = 0;
        m_gnt   = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, int'(out_valid), (m_owner >= 0) ? 1 : 0);
        chk({tag, ".data"},  int'(out_data),  (m_owner >= 0) ? m_word : 0);
        chk({tag, ".sel"},   int'(sel),       (m_owner >= 0) ? m_owner : 7);
        chk({tag, ".gnt"},   int'(gnt),       m_gnt);
        chk({tag, ".busy"},  int'(busy),      (m_owner >= 0) ? 1 : 0);
    endtask

    // Advance one clock with the currently driven inputs, then compare every output.
    task automatic step(input string tag);
        int w;
        m_gnt = 0;
        if (m_owner < 0) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_word  = int'(dat[w]);
            end
        end else if (out_ready) begin
            m_gnt = 1 << m_owner;
`ifdef MUX6_ARB_PRIO0_EN
            if (m_owner != 0) m_ptr = m_owner;
`else
            m_ptr = m_owner;
`endif
            m_owner = -1;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        $display("step %-6s req=%b rdy=%0d -> valid=%0d data=%h sel=%0d gnt=%b busy=%0d",
                 tag, req, out_ready, out_valid, out_data, sel, gnt, busy);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("rst");
        areset = 1'b0;
    endtask

    // Reset asserted between edges must clear outputs at once, with no gnt.
    task automatic mid_cycle_reset();
        #2;
        areset = 1'b1;
        #1;
        model_reset();
        check_outputs("arst");
        @(posedge clk);
        #1;
        check_outputs("arst2");
        areset = 1'b0;
    endtask

`ifdef MUX6_ARB_PRIO0_EN
    int rr_exp[7]   = '{1, 1, 1, 1, 1, 1, 1};
    int wrap_exp[4] = '{0, 0, 0, 0};
`else
    int rr_exp[7]   = '{1, 2, 3, 4, 5, 6, 1};
    int wrap_exp[4] = '{0, 1, 5, 0};
`endif

    initial begin
        int n;
        areset    = 1'b1;
        req       = 6'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) dat[i] = '0;
        model_reset();
        #2;
        check_outputs("por");
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Single request from source 2.
        req = 6'b000100; dat[2] = 4'hA; out_ready = 1'b1;
        step("single");
        chk("single.word", int'(out_data), 10);
        chk("single.sel", int'(sel), 2);
        req = 6'b000000;
        step("single");
        chk("single.gnt", int'(gnt), 6'b000100);

        // Round-robin with every source requesting.
        do_reset();
        for (int i = 0; i < 6; i++) dat[i] = 4'(i + 1);
        req = 6'b111111; out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 14; c++) begin
            step("rr");
            if (m_owner >= 0 && n < 7) begin
                chk("rr.seq", int'(out_data), rr_exp[n]);
                n++;
            end
        end

        // Backpressure on source 4 while its data and request change.
        do_reset();
        req = 6'b010000; dat[4] = 4'h7; out_ready = 1'b0;
        step("bp");
        for (int c = 0; c < 5; c++) begin
            dat[4] = 4'($urandom_range(0, 15));
            req = 6'b000000;
            step("bp");
            chk("bp.hold", int'(out_data), 7);
        end
        out_ready = 1'b1;
        step("bp");
        chk("bp.gnt", int'(gnt), 6'b010000);
        step("bp");

        // Wrap-around after serving source 5.
        do_reset();
        for (int i = 0; i < 6; i++) dat[i] = 4'(i + 8);
        req = 6'b100000; out_ready = 1'b1;
        step("wrap");
        step("wrap");
        req = 6'b100011;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            step("wrap");
            if (m_owner >= 0 && n < 4) begin
                chk("wrap.seq", int'(sel), wrap_exp[n]);
                n++;
            end
        end

        // Randomized traffic with occasional reset while a word is held.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req = ($urandom_range(0, 3) == 0) ? 6'b0 : 6'($urandom_range(0, 63));
            for (int i = 0; i < 6; i++) dat[i] = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            if (m_owner >= 0 && $urandom_range(0, 29) == 0) begin
                mid_cycle_reset();
            end else begin
                step("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
